stepper_key_debounce: RTL



---
 rtl/stepper_key_pkg.sv | 16 +
 rtl/key_debounce_cell.sv | 120 ++++++++++++
 rtl/stepper_key_debounce.sv | 32 +++
 3 files changed

// File: rtl/stepper_key_pkg.sv
// Shared types and default timing constants for the key debouncer.
// Optional auto-repeat build switch: KEY_DEBOUNCE_AUTOREPEAT_EN.
package stepper_key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } key_db_state_t;

  localparam int KEY_DB_CYCLES_DEFAULT     = 50000;
  localparam int KEY_REPEAT_DELAY_DEFAULT  = 25000000;
  localparam int KEY_REPEAT_PERIOD_DEFAULT = 5000000;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchronizer, debounce FSM and optional repeat counter.
// Auto-repeat is built only when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce_cell
  import stepper_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DB_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_out,
  output logic key_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic q1;
  logic q2;
  key_db_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic out_n;
  logic prs_n;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  logic [RW-1:0] rcnt, rcnt_n;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q1          <= 1'b1;
      q2          <= 1'b1;
      state       <= RELEASED;
      cnt         <= '0;
      key_out     <= 1'b1;
      key_pressed <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rcnt        <= '0;
`endif
    end else begin
      q1          <= key_raw;
      q2          <= q1;
      state       <= state_n;
      cnt         <= cnt_n;
      key_out     <= out_n;
      key_pressed <= prs_n;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rcnt        <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    out_n   = key_out;
    prs_n   = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!q2) begin
          state_n = PRESS_PEND;
          cnt_n   = CW'(1);
        end
      end
      PRESS_PEND: begin
        if (q2) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = PRESSED;
          out_n   = 1'b0;
          prs_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (q2) begin
          state_n = RELEASE_PEND;
          cnt_n   = CW'(1);
        end
      end
      RELEASE_PEND: begin
        if (!q2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = RELEASED;
          out_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RELEASED;
    endcase

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    // An accepted release wins over a repeat due on the same edge
    rcnt_n = rcnt;
    if (state_n == RELEASED) begin
      rcnt_n = '0;
    end else if (state == PRESSED || state == RELEASE_PEND) begin
      if (rcnt == RW'(REPEAT_DELAY - 1)) begin
        prs_n  = 1'b1;
        rcnt_n = RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
    end else begin
      rcnt_n = '0;
    end
`endif
  end

endmodule

// File: rtl/stepper_key_debounce.sv
// Debounces NUM_KEYS active-low push-buttons ahead of the key PIO.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add held-key repeat strobes.
module stepper_key_debounce
  import stepper_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DB_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_pressed
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_raw[i]),
      .key_out    (key_out[i]),
      .key_pressed(key_pressed[i])
    );
  end

endmodule
